// File: rtl/imem_loader.sv
// imem_loader: byte-addressed instruction memory with serial program loader (IMEM_ADDR_CHECK_EN enables fetch address checking)
module imem_loader #(
  parameter int NBITS = 8,
  parameter int INST_BITS = 32,
  parameter int CELLS = 256,
  parameter int ADDR_BITS = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter logic [INST_BITS-1:0] HALT_INST = {INST_BITS{1'b1}}
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic                                        i_step,
  input  logic [ADDR_BITS-1:0]                        i_addr,
  output logic [INST_BITS-1:0]                        o_data,
  output logic                                        o_valid,
  output logic                                        o_misaligned,
  input  logic                                        i_dbg_start,
  input  logic [NBITS-1:0]                            i_dbg_byte,
  input  logic                                        i_dbg_valid,
  output logic                                        o_dbg_ready,
  output logic [$clog2(CELLS/(INST_BITS/NBITS)):0]    o_dbg_words,
  output logic                                        o_load_done
);
  localparam int BYTES = INST_BITS / NBITS;
  localparam int AW = $clog2(CELLS);
  localparam int PW = $clog2(CELLS + 1);
  localparam int WW = $clog2(CELLS / BYTES) + 1;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state;
  logic [PW-1:0] ptr;
  logic [INST_BITS-1:0] asm_q, asm_n, word;
  logic [NBITS-1:0] mem [CELLS];
  logic [ADDR_BITS-1:0] base;
  logic bad, accept, fetch, wb;
  assign accept = state == LOAD && i_dbg_valid && o_dbg_ready;
  assign fetch = state == IDLE && i_step;
  assign asm_n = INST_BITS'({asm_q, i_dbg_byte});
  assign wb = ptr % PW'(BYTES) == PW'(BYTES - 1);
`ifdef IMEM_ADDR_CHECK_EN
  assign bad = i_addr % ADDR_BITS'(BYTES) != '0 || i_addr > ADDR_BITS'(CELLS - BYTES);
  assign base = bad ? '0 : i_addr;
`else
  logic [ADDR_BITS-1:0] wrapped;
  assign wrapped = i_addr % ADDR_BITS'(CELLS);
  assign bad = 1'b0;
  assign base = wrapped - wrapped % ADDR_BITS'(BYTES);
`endif
  always_comb begin
    word = '0;
    for (int k = 0; k < BYTES; k++)
      word[(BIG_ENDIAN ? BYTES - 1 - k : k) * NBITS +: NBITS] = mem[AW'(base) + AW'(k)];
  end
  always_ff @(posedge i_clk)
    if (!i_rst && accept) mem[AW'(ptr)] <= i_dbg_byte;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      ptr <= '0;
      asm_q <= '0;
      o_data <= '0;
      o_valid <= 1'b0;
      o_misaligned <= 1'b0;
      o_dbg_ready <= 1'b0;
      o_dbg_words <= '0;
      o_load_done <= 1'b0;
    end else begin
      o_valid <= fetch;
      if (fetch) begin
        o_data <= bad ? '0 : word;
        o_misaligned <= bad;
      end
      case (state)
        IDLE:
          if (i_dbg_start) begin
            state <= LOAD;
            ptr <= '0;
            o_dbg_words <= '0;
            o_dbg_ready <= 1'b1;
          end
        LOAD:
          if (i_dbg_start) begin
            ptr <= '0;
            o_dbg_words <= '0;
          end else if (accept) begin
            ptr <= ptr + PW'(1);
            asm_q <= asm_n;
            if (wb) o_dbg_words <= o_dbg_words + WW'(1);
            if ((wb && asm_n == HALT_INST) || ptr == PW'(CELLS - 1)) begin
              state <= DONE;
              o_dbg_ready <= 1'b0;
              o_load_done <= 1'b1;
            end
          end
        default: begin
          state <= IDLE;
          o_load_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst, step, dbg_start, dbg_valid;
  logic [31:0] addr;
  logic [7:0] dbg_byte;
  logic [31:0] b_data, l_data, s_data;
  logic b_valid, l_valid, s_valid, b_mis, l_mis, s_mis;
  logic b_ready, l_ready, s_ready, b_done, l_done, s_done;
  logic [6:0] b_words, l_words;
  logic [1:0] s_words;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  imem_loader u_big (
    .i_clk(clk), .i_rst(rst), .i_step(step), .i_addr(addr),
    .o_data(b_data), .o_valid(b_valid), .o_misaligned(b_mis),
    .i_dbg_start(dbg_start), .i_dbg_byte(dbg_byte), .i_dbg_valid(dbg_valid),
    .o_dbg_ready(b_ready), .o_dbg_words(b_words), .o_load_done(b_done)
  );
  imem_loader #(.BIG_ENDIAN(1'b0)) u_le (
    .i_clk(clk), .i_rst(rst), .i_step(step), .i_addr(addr),
    .o_data(l_data), .o_valid(l_valid), .o_misaligned(l_mis),
    .i_dbg_start(dbg_start), .i_dbg_byte(dbg_byte), .i_dbg_valid(dbg_valid),
    .o_dbg_ready(l_ready), .o_dbg_words(l_words), .o_load_done(l_done)
  );
  imem_loader #(.CELLS(8)) u_small (
    .i_clk(clk), .i_rst(rst), .i_step(step), .i_addr(addr),
    .o_data(s_data), .o_valid(s_valid), .o_misaligned(s_mis),
    .i_dbg_start(dbg_start), .i_dbg_byte(dbg_byte), .i_dbg_valid(dbg_valid),
    .o_dbg_ready(s_ready), .o_dbg_words(s_words), .o_load_done(s_done)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    dbg_byte = b;
    dbg_valid = 1'b1;
    tick();
    dbg_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    step = 1'b0;
    dbg_start = 1'b0;
    dbg_valid = 1'b0;
    addr = '0;
    dbg_byte = '0;
    tick();
    tick();
    chk("rst_data", b_data, 0);
    chk("rst_valid", b_valid, 0);
    chk("rst_mis", b_mis, 0);
    chk("rst_ready", b_ready, 0);
    chk("rst_words", b_words, 0);
    chk("rst_done", b_done, 0);
    rst = 1'b0;
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    chk("load_ready", b_ready, 1);
    chk("load_ready_small", s_ready, 1);
    send(8'h8C);
    send(8'h01);
    send(8'h00);
    send(8'h04);
    chk("words_after_4", b_words, 1);
    send(8'hFF);
    send(8'hFF);
    send(8'hFF);
    chk("no_done_before_halt", b_done, 0);
    send(8'hFF);
    chk("halt_done", b_done, 1);
    chk("halt_ready", b_ready, 0);
    chk("halt_words", b_words, 2);
    chk("le_halt_done", l_done, 1);
    chk("le_halt_words", l_words, 2);
    chk("small_done", s_done, 1);
    chk("small_words", s_words, 2);
    step = 1'b1;
    addr = 32'd0;
    tick();
    chk("done_pulse_end", b_done, 0);
    chk("fetch_blocked_done", b_valid, 0);
    tick();
    chk("fetch0_valid", b_valid, 1);
    chk("fetch0_be", b_data, 32'h8C010004);
    chk("fetch0_le", l_data, 32'h0400018C);
    chk("fetch0_small", s_data, 32'h8C010004);
    chk("fetch0_mis", b_mis, 0);
    addr = 32'd4;
    tick();
    chk("fetch4_halt", b_data, 32'hFFFFFFFF);
    addr = 32'd0;
    tick();
    step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", b_valid, 0);
      chk("hold_data", b_data, 32'h8C010004);
    end
    step = 1'b1;
    addr = 32'd2;
    tick();
    chk("addr2_valid", b_valid, 1);
`ifdef IMEM_ADDR_CHECK_EN
    chk("addr2_mis", b_mis, 1);
    chk("addr2_data", b_data, 0);
`else
    chk("addr2_mis", b_mis, 0);
    chk("addr2_data", b_data, 32'h8C010004);
`endif
    addr = 32'd256;
    tick();
`ifdef IMEM_ADDR_CHECK_EN
    chk("addr256_mis", b_mis, 1);
    chk("addr256_data", b_data, 0);
`else
    chk("addr256_data", b_data, 32'h8C010004);
`endif
    addr = 32'd252;
    tick();
    chk("addr252_mis", b_mis, 0);
    chk("addr252_valid", b_valid, 1);
    addr = 32'd262;
    tick();
`ifdef IMEM_ADDR_CHECK_EN
    chk("addr262_mis", b_mis, 1);
    chk("addr262_data", b_data, 0);
`else
    chk("addr262_mis", b_mis, 0);
    chk("addr262_data", b_data, 32'hFFFFFFFF);
`endif
    step = 1'b0;
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i));
    chk("ovf_done", s_done, 1);
    chk("ovf_ready", s_ready, 0);
    chk("ovf_words", s_words, 2);
    chk("big_still_loading", b_ready, 1);
    chk("big_no_done", b_done, 0);
    for (int i = 9; i <= 12; i++) send(8'(i));
    chk("ovf_words_after", s_words, 2);
    chk("ovf_ready_after", s_ready, 0);
    chk("big_words_12", b_words, 3);
    chk("big_ready_12", b_ready, 1);
    step = 1'b1;
    addr = 32'd0;
    tick();
    chk("ovf_fetch0_valid", s_valid, 1);
    chk("ovf_fetch0", s_data, 32'h01020304);
    chk("fetch_in_load", b_valid, 0);
    chk("fetch_in_load_le", l_valid, 0);
    addr = 32'd4;
    tick();
    chk("ovf_fetch4", s_data, 32'h05060708);
    addr = 32'd8;
    tick();
`ifdef IMEM_ADDR_CHECK_EN
    chk("ovf_fetch8_mis", s_mis, 1);
    chk("ovf_fetch8", s_data, 0);
`else
    chk("ovf_fetch8_wrap", s_data, 32'h01020304);
`endif
    step = 1'b0;
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    chk("restart_words", b_words, 0);
    chk("restart_ready", b_ready, 1);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    chk("partial_ready", b_ready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", b_ready, 0);
    chk("midrst_words", b_words, 0);
    chk("midrst_valid", b_valid, 0);
    chk("midrst_ready_small", s_ready, 0);
    step = 1'b1;
    addr = 32'd0;
    tick();
    chk("partial_valid", b_valid, 1);
    chk("partial_be", b_data, 32'hAABBCC04);
    chk("partial_le", l_data, 32'h04CCBBAA);
    chk("partial_small", s_data, 32'hAABBCC04);
    addr = 32'd4;
    dbg_start = 1'b1;
    tick();
    dbg_start = 1'b0;
    chk("simul_valid", b_valid, 1);
    chk("simul_data", b_data, 32'h05060708);
    chk("simul_ready", b_ready, 1);
    tick();
    chk("simul_blocked", b_valid, 0);
    chk("simul_hold", b_data, 32'h05060708);
    step = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
